// File: rtl/mod_counter_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : mod_counter_bank_if
//  Purpose  : Control and status bundle for the modulo counter bank.
//             Carries the per-channel enables, directions, clears and chain
//             requests, the modulus-write port, and the count and tc outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface mod_counter_bank_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
);
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       up_dn;
  logic [NUM_CH-1:0]       clr;
  logic [NUM_CH-1:0]       cascade;
  logic                    cfg_wr;
  logic [3:0]              cfg_ch;
  logic [WIDTH-1:0]        cfg_mod;
  logic [NUM_CH*WIDTH-1:0] count;
  logic [NUM_CH-1:0]       tc;

  // Controller side: drives the controls, observes the counters
  modport master (
    output en, up_dn, clr, cascade, cfg_wr, cfg_ch, cfg_mod,
    input  count, tc
  );

  // Counter-bank side
  modport slave (
    input  en, up_dn, clr, cascade, cfg_wr, cfg_ch, cfg_mod,
    output count, tc
  );
endinterface
`default_nettype wire

// File: rtl/mod_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module   : mod_counter_bank
//  Purpose  : NUM_CH independent run-time-programmable modulo counters with
//             up/down direction, synchronous clear and a registered
//             terminal-count pulse.
//             Optional macro MODCNT_CASCADE_EN: a channel with its cascade
//             bit set steps only when the channel below it wraps in the same
//             cycle (combinational ripple, whole chain advances on one edge).
//  Revision : 1.0  initial release
// ============================================================================
module mod_counter_bank #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 8,
  parameter int MOD_RST = 10
) (
  input wire                clk,
  input wire                rst_n,
  mod_counter_bank_if.slave bus
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] r_mod;
    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;
    logic [WIDTH-1:0] w_mod_eff;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_next;
    logic             w_cfg_hit;
    logic             w_step;
    logic             w_at_end;
    logic             w_wrap;

    // A zero modulus behaves like one: the counter parks at 0 and every step wraps
    assign w_mod_eff = (r_mod == '0) ? WIDTH'(1) : r_mod;
    assign w_top     = w_mod_eff - WIDTH'(1);

    // Writes aimed at a channel index beyond the bank never match anything
    assign w_cfg_hit = bus.cfg_wr && (bus.cfg_ch == 4'(i));

`ifdef MODCNT_CASCADE_EN
    if (i == 0) begin : g_head
      assign w_step = bus.en[i];
    end else begin : g_link
      // Chained channel advances on the same edge the lower channel wraps
      assign w_step = bus.cascade[i] ? (bus.en[i] & g_ch[i-1].w_wrap) : bus.en[i];
    end
`else
    assign w_step = bus.en[i];
`endif

    assign w_at_end = bus.up_dn[i] ? (r_cnt == w_top) : (r_cnt == '0);

    // A wrap only counts when the step actually lands; cfg and clr override it
    assign w_wrap = w_step & ~w_cfg_hit & ~bus.clr[i] & w_at_end;

    assign w_next = w_at_end ? (bus.up_dn[i] ? '0 : w_top)
                             : (bus.up_dn[i] ? r_cnt + WIDTH'(1) : r_cnt - WIDTH'(1));

    // Channel state: priority is cfg write, then clear, then step
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mod <= WIDTH'(MOD_RST);
        r_cnt <= '0;
        r_tc  <= 1'b0;
      end else begin
        r_tc <= w_wrap;
        if (w_cfg_hit) begin
          r_mod <= bus.cfg_mod;
          r_cnt <= '0;
        end else if (bus.clr[i]) begin
          r_cnt <= '0;
        end else if (w_step) begin
          r_cnt <= w_next;
        end
      end
    end

    assign bus.count[i*WIDTH +: WIDTH] = r_cnt;
    assign bus.tc[i]                   = r_tc;
  end : g_ch

  // Chain requests that have no effect in this build
  logic w_unused_cascade;
`ifdef MODCNT_CASCADE_EN
  assign w_unused_cascade = bus.cascade[0];
`else
  assign w_unused_cascade = ^bus.cascade;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_counter_bank
//  Purpose  : Directed self-checking bench for mod_counter_bank (4 x 8-bit
//             bank plus a single 4-bit channel for the width corner).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mod_counter_bank;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  mod_counter_bank_if #(.NUM_CH(4), .WIDTH(8)) bus  ();
  mod_counter_bank_if #(.NUM_CH(1), .WIDTH(4)) bus4 ();

  mod_counter_bank #(.NUM_CH(4), .WIDTH(8), .MOD_RST(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  mod_counter_bank #(.NUM_CH(1), .WIDTH(4), .MOD_RST(10)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pk(input int c3, input int c2, input int c1, input int c0);
    return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  function automatic logic [7:0] cnt(input int ch);
    return bus.count[ch*8 +: 8];
  endfunction

  initial begin
    int e1;
    n_checks = 0;
    n_err    = 0;
    rst_n = 1'b0;
    bus.en = '0; bus.up_dn = '1; bus.clr = '0; bus.cascade = '0;
    bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_mod = '0;
    bus4.en = '0; bus4.up_dn = '1; bus4.clr = '0; bus4.cascade = '0;
    bus4.cfg_wr = 1'b0; bus4.cfg_ch = '0; bus4.cfg_mod = '0;

    // ---- reset state ----
    #3;
    chk("rst_count", 64'(bus.count), 64'(0));
    chk("rst_tc",    64'(bus.tc),    64'(0));
    tick();
    rst_n = 1'b1;

    // ---- reset modulus 10, up count 0..9,0 ----
    bus.en = 4'hF;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk($sformatf("up10_cnt_t%0d", k), 64'(bus.count), 64'(pk(k % 10, k % 10, k % 10, k % 10)));
      chk($sformatf("up10_tc_t%0d", k),  64'(bus.tc),    64'((k == 10) ? 4'hF : 4'h0));
    end

    // ---- asynchronous reset mid-count ----
    for (int k = 0; k < 4; k++) tick();
    chk("pre_rst_cnt", 64'(bus.count), 64'(pk(5, 5, 5, 5)));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", 64'(bus.count), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // ---- modulus write on channel 2 while at 7 ----
    for (int k = 0; k < 7; k++) tick();
    chk("pre_cfg_cnt", 64'(bus.count), 64'(pk(7, 7, 7, 7)));
    bus.cfg_wr = 1'b1; bus.cfg_ch = 4'd2; bus.cfg_mod = 8'd3;
    tick();
    bus.cfg_wr = 1'b0;
    chk("cfg_a_cnt", 64'(bus.count), 64'(pk(8, 0, 8, 8)));
    chk("cfg_a_tc",  64'(bus.tc),    64'(0));
    tick();
    chk("cfg_b_cnt", 64'(bus.count), 64'(pk(9, 1, 9, 9)));
    tick();
    chk("cfg_c_cnt", 64'(bus.count), 64'(pk(0, 2, 0, 0)));
    chk("cfg_c_tc",  64'(bus.tc),    64'(4'b1011));
    tick();
    chk("cfg_d_cnt", 64'(bus.count), 64'(pk(1, 0, 1, 1)));
    chk("cfg_d_tc",  64'(bus.tc),    64'(4'b0100));

    // ---- down count, modulus 5 on channel 1 ----
    bus.en = 4'b0010; bus.up_dn = 4'b1101;
    bus.cfg_wr = 1'b1; bus.cfg_ch = 4'd1; bus.cfg_mod = 8'd5;
    tick();
    bus.cfg_wr = 1'b0;
    chk("dn_cfg_cnt", 64'(cnt(1)), 64'(0));
    begin
      int dseq[6] = '{4, 3, 2, 1, 0, 4};
      for (int k = 0; k < 6; k++) begin
        tick();
        chk($sformatf("dn5_cnt_%0d", k), 64'(cnt(1)), 64'(dseq[k]));
        chk($sformatf("dn5_tc_%0d", k),  64'(bus.tc[1]), 64'((k == 0 || k == 5) ? 1 : 0));
      end
    end
    chk("dn5_others", 64'(bus.count), 64'(pk(1, 0, 4, 1)));

    // ---- degenerate moduli 0 (ch0) and 1 (ch3) ----
    bus.en = '0; bus.up_dn = 4'b0001;
    bus.cfg_wr = 1'b1; bus.cfg_ch = 4'd0; bus.cfg_mod = 8'd0;
    tick();
    bus.cfg_ch = 4'd3; bus.cfg_mod = 8'd1;
    tick();
    bus.cfg_wr = 1'b0;
    bus.en = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("deg_cnt_%0d", k), 64'({cnt(3), cnt(0)}), 64'(0));
      chk($sformatf("deg_tc_%0d", k),  64'(bus.tc), 64'(4'b1001));
    end

    // ---- reset drops a pending tc and restores modulus 10 ----
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tc_drop", 64'(bus.tc),    64'(0));
    chk("rst_cnt_zero", 64'(bus.count), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.en = 4'hF; bus.up_dn = 4'hF;
    for (int k = 0; k < 10; k++) tick();
    chk("modrst_wrap_cnt", 64'(bus.count), 64'(0));
    chk("modrst_wrap_tc",  64'(bus.tc),    64'(4'hF));

    // ---- priority: cfg over clr over step ----
    for (int k = 0; k < 3; k++) tick();
    bus.cfg_wr = 1'b1; bus.cfg_ch = 4'd0; bus.cfg_mod = 8'd4;
    bus.clr = 4'b0011;
    tick();
    bus.cfg_wr = 1'b0; bus.clr = '0;
    chk("prio_cnt", 64'(bus.count), 64'(pk(4, 4, 0, 0)));
    chk("prio_tc",  64'(bus.tc),    64'(0));
    for (int k = 0; k < 4; k++) tick();
    chk("prio_mod4_cnt", 64'(bus.count), 64'(pk(8, 8, 4, 0)));
    chk("prio_mod4_tc",  64'(bus.tc),    64'(4'b0001));
    tick();
    bus.clr = 4'b0100;
    tick();
    bus.clr = '0;
    chk("clr_wrap_cnt", 64'(bus.count), 64'(pk(0, 0, 6, 2)));
    chk("clr_wrap_tc",  64'(bus.tc),    64'(4'b1000));

    // ---- out-of-range cfg channel is a no-op ----
    bus.en = '0;
    bus.cfg_wr = 1'b1; bus.cfg_ch = 4'd15; bus.cfg_mod = 8'd2;
    tick();
    bus.cfg_wr = 1'b0;
    chk("cfg15_cnt", 64'(bus.count), 64'(pk(0, 0, 6, 2)));
    bus.en = 4'hF;
    tick();
    chk("cfg15_step", 64'(bus.count), 64'(pk(1, 1, 7, 3)));
    tick();
    chk("cfg15_mods", 64'(bus.count), 64'(pk(2, 2, 8, 0)));

    // ---- cascade: ch0 mod 10, ch1 mod 6 ----
    bus.en = '0;
    bus.cfg_wr = 1'b1; bus.cfg_ch = 4'd0; bus.cfg_mod = 8'd10;
    tick();
    bus.cfg_ch = 4'd1; bus.cfg_mod = 8'd6;
    tick();
    bus.cfg_wr = 1'b0;
    bus.cascade = 4'b0010; bus.en = 4'b0011;
    for (int t = 1; t <= 60; t++) begin
      tick();
`ifdef MODCNT_CASCADE_EN
      e1 = (t / 10) % 6;
`else
      e1 = t % 6;
`endif
      if (t == 1 || t == 10 || t == 60) begin
        chk($sformatf("casc_ch0_t%0d", t), 64'(cnt(0)), 64'(t % 10));
        chk($sformatf("casc_ch1_t%0d", t), 64'(cnt(1)), 64'(e1));
      end
    end
    chk("casc_tc1_t60", 64'(bus.tc[1]), 64'(1));
    bus.en = '0; bus.cascade = '0;

    // ---- 4-bit width corner, modulus 15 ----
    bus4.cfg_wr = 1'b1; bus4.cfg_ch = 4'd0; bus4.cfg_mod = 4'd15;
    tick();
    bus4.cfg_wr = 1'b0;
    bus4.en = 1'b1; bus4.up_dn = 1'b1;
    for (int k = 0; k < 14; k++) tick();
    chk("w4_cnt14", 64'(bus4.count), 64'(14));
    chk("w4_tc14",  64'(bus4.tc),    64'(0));
    tick();
    chk("w4_cnt_wrap", 64'(bus4.count), 64'(0));
    chk("w4_tc_wrap",  64'(bus4.tc),    64'(1));
    tick();
    chk("w4_cnt_after", 64'(bus4.count), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod_counter_bank.md
# mod_counter_bank

Bank of NUM_CH independent modulo counters. Each channel has a modulus that is programmable at run time, up/down direction, a synchronous clear, and a registered terminal-count pulse. An optional cascade mode chains adjacent channels into multi-digit counters. The block replaces fixed-modulus counter groups in timing and sequencing logic wherever run-time-selectable cycle lengths are needed.

## Interface
- NUM_CH, 4: number of counter channels (1..16)
- WIDTH, 8: counter and modulus width in bits (2..16)
- MOD_RST, 10: modulus loaded into every channel at reset (must fit in WIDTH)

- clk  in  1: rising-edge clock, single clock domain
- rst_n  in  1: reset; one clock; reset is asynchronous and active-low
- en  in  NUM_CH: per-channel count enable
- up_dn  in  NUM_CH: per-channel direction (1 = up, 0 = down)
- clr  in  NUM_CH: per-channel synchronous clear to 0
- cascade  in  NUM_CH: per-channel chain request (bit 0 ignored)
- cfg_wr  in  1: modulus write strobe
- cfg_ch  in  4: target channel for cfg_wr
- cfg_mod  in  WIDTH: new modulus value
- count  out  NUM_CH*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH]
- tc  out  NUM_CH: per-channel terminal-count pulse

## Operation
- State per channel: mod[i] (WIDTH bits) and count[i] (WIDTH bits).
- Effective modulus M = max(mod[i], 1). The count range is 0..M-1. With M = 1, count stays at 0 and every step is a wrap.
- Step condition: step[i] = en[i], except when cascade mode is active for channel i (see Configuration).
- Up step: if count == M-1, count becomes 0 and the step is a wrap. Otherwise count increments by 1.
- Down step: if count == 0, count becomes M-1 and the step is a wrap. Otherwise count decrements by 1.
- wrap[i] is the combinational wrap indication for the current cycle.
- tc[i] is registered: it is 1 for exactly the cycle following a wrapping step, and 0 otherwise.
- Per-channel priority, highest first: reset, cfg write, clr, step.
  - cfg write: when cfg_wr = 1 and cfg_ch == i, mod[i] loads cfg_mod, count[i] loads 0, and tc[i] goes to 0.
  - clr: count[i] loads 0, tc[i] goes to 0, mod[i] is unchanged.
- A cfg_ch value ≥ NUM_CH makes the write a no-op for all channels.
- A modulus write always clears count, so count is never ≥ M.
- Changing up_dn mid-count takes effect on the next step. No clear is implied.
- Arithmetic is unsigned and modulo 2^WIDTH before the wrap compare. M-1 is computed in WIDTH bits.

## Timing
- Reset (rst_n = 0) is asynchronous and takes effect immediately. Values while held:
  - count = 0 on all channels
  - tc = 0 on all channels
  - mod = MOD_RST on all channels
- Reset deassertion must be synchronous to clk externally. The first step can occur on the first rising edge with rst_n = 1.
- Latency: an en sampled at edge k changes count at edge k. The new value is visible after edge k, and tc is asserted for the cycle following edge k.
- A cfg write at edge k takes effect at edge k. en on that channel at edge k is ignored.
- Reset mid-count: all state returns to reset values immediately, and a pending tc is dropped.
- Channel updates are simultaneous and independent. A cfg write to one channel does not stall the others.

## Configuration
- MODCNT_CASCADE_EN defined:
  - For i ≥ 1 with cascade[i] = 1, step[i] = en[i] & wrap[i-1] in the same cycle. This is a ripple within one clock, so a chain of any length advances on the same edge.
  - cascade[0] is ignored.
  - clr or a cfg write on channel i-1 produces no wrap for channel i.
- MODCNT_CASCADE_EN undefined:
  - The cascade port remains in the port list but is ignored.
  - step[i] = en[i] for every channel.
  - No inter-channel logic is synthesised.

## Test plan
- Reset: hold rst_n = 0 mid-count → count = 0, tc = 0, and mod = 10. With all en high and up, count runs 0..9,0 with tc high for one cycle after the 9→0 edge.
- Modulus write: cfg_ch = 2, cfg_mod = 3 while channel 2 is at 7 → channel 2 reads 0 next cycle, then runs 0,1,2,0, and channels 0, 1, 3 are unaffected.
- Down and degenerate moduli:
  - mod = 5, up_dn = 0 from 0 → count 4,3,2,1,0,4 with tc after the 0→4 step.
  - mod = 0 or 1 → count stays 0 and tc is high every enabled cycle.
- Priority: cfg_wr, clr and en asserted on the same channel in the same cycle → cfg write wins. clr with en (no cfg write) → count = 0 and tc = 0. cfg_ch = 15 with NUM_CH = 4 → no change on any channel.
- Cascade (MODCNT_CASCADE_EN): ch0 mod 10, ch1 mod 6 with cascade[1] = 1, both enabled → ch1 advances only on the edge where ch0 wraps 9→0. After 60 cycles both read 0 with tc[1] = 1. The same test without the macro → ch1 counts every cycle.
- Width corner: WIDTH = 4, cfg_mod = 15 up → count 0..14,0, with no 4-bit overflow artifacts.
